unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock and reset are the first two ports.
REQ-002 clock  input  1  rising-edge system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising clock edge.
REQ-004 run  input  1  start request; sampled only in state T0.
REQ-005 instr  input  9  instruction word [8:6] opcode, [5:3] Rx, [2:0] Ry; captured when a start is accepted.
REQ-006 select  output  3  register index driven to the bus multiplexer; 000 when unused.
REQ-007 rSelect  output  1  selects ALU result register G onto the bus; 0 when unused.
REQ-008 immeSelect  output  1  selects the immediate operand onto the bus; 0 when unused.
REQ-009 rIn  output  8  one-hot load enable for R0..R7; all zero when no write.
REQ-010 aIn  output  1  load enable for ALU operand register A.
REQ-011 gIn  output  1  load enable for ALU result register G.
REQ-012 aluOp  output  2  00 add, 01 sub, 10 and; 00 when gIn=0.
REQ-013 done  output  1  one-cycle pulse in the final cycle of an instruction.
REQ-014 busy  output  1  high in every state except T0.

Function
REQ-015 The FSM SHALL have states T0, T1, T2 and T3, encoded in a 2-bit register.
REQ-016 The block SHALL hold a 9-bit internal register ir, loaded from instr on the edge that leaves T0.
REQ-017 Outputs SHALL be combinational decodes of state and ir only; no output depends on run or instr.
REQ-018 Every output not explicitly asserted in a state SHALL be 0.
REQ-019 T0: all outputs 0; run=1 -> load ir, go to T1; run=0 -> stay in T0.
REQ-020 T1, opcode 000 (mv): select=Ry, rIn[Rx]=1, done=1; next state T0.
REQ-021 T1, opcode 001 (mvi): immeSelect=1, rIn[Rx]=1, done=1; next state T0.
REQ-022 T1, opcodes 010/011/100 (add/sub/and): select=Rx, aIn=1; next state T2.
REQ-023 T1, opcodes 101-111 (nop): done=1, no enables asserted; next state T0.
REQ-024 T2: select=Ry, gIn=1, aluOp = 00 for add, 01 for sub, 10 for and; next state T3.
REQ-025 T3: rSelect=1, rIn[Rx]=1, done=1; next state T0.
REQ-026 Bus-select priority: at most one of {select used, rSelect, immeSelect} SHALL be active per cycle.
- immeSelect=1 implies rSelect=0 and select=000.
- rSelect=1 implies select=000.
REQ-027 Latency from the T0 edge accepting run: mv, mvi and nop finish in 1 cycle (T1); ALU operations finish in 3 cycles (T1-T3).
REQ-028 run SHALL be ignored while busy=1; held run SHALL start a new instruction on the T0 cycle immediately after done (back-to-back, no gap state).
REQ-029 Changes to instr while busy=1 SHALL have no effect on the outputs.
REQ-030 Rx=Ry SHALL be legal; the sequence is unchanged (e.g. add R3,R3 doubles R3).
REQ-031 rIn SHALL never have more than one bit set.

Reset
REQ-032 reset=1 on an edge SHALL force state=T0 and ir=0 regardless of current state, including mid-instruction (T1/T2/T3).
REQ-033 In the cycle after reset, all outputs SHALL be 0, busy=0 and done=0.
REQ-034 reset SHALL take priority over run on the same edge; the instruction is not captured.
REQ-035 An interrupted instruction SHALL not be resumed; no pending done SHALL be produced.

Verification
REQ-036 Run mv R2,R5: reset, run=1, instr=000_010_101 -> T1 shows select=101, rIn=00000100, done=1; then T0 with all outputs 0.
REQ-037 Run mvi R7: instr=001_111_000 -> T1 shows immeSelect=1, select=000, rIn=10000000, done=1.
REQ-038 Run sub R1,R4: instr=011_001_100 -> expected sequence:
- T1: select=001, aIn=1.
- T2: select=100, gIn=1, aluOp=01.
- T3: rSelect=1, rIn=00000010, done=1.
- busy=1 for exactly 3 cycles.
REQ-039 Back-to-back: run held high with add R0,R1, then mv R3,R0 presented after the first done -> second T1 immediately follows the first T0; instr changes during T2 are ignored.
REQ-040 Reset mid-op: assert reset during T2 of an and -> next cycle T0, all outputs 0, no done; same-edge run=1 with reset=1 is ignored.
REQ-041 Nop and random: opcode 110 -> done in T1 with rIn=0; a random instruction stream checks REQ-026 and REQ-031 every cycle.

Source files
------------

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//
// Control unit for a small register-machine datapath. An instruction word
// is captured when a start is accepted in the idle state T0. The unit then
// sequences the bus multiplexer and the register load enables for one
// (mv, mvi, nop) or three (add, sub, and) cycles.
//
// Instruction word: [8:6] opcode, [5:3] Rx, [2:0] Ry
//   000 mv  Rx <- Ry          001 mvi Rx <- immediate
//   010 add Rx <- Rx + Ry     011 sub Rx <- Rx - Ry
//   100 and Rx <- Rx & Ry     101..111 nop
//
// Ports
//   clock      in   rising-edge system clock
//   reset      in   synchronous, active-high reset
//   run        in   start request, only looked at in T0
//   instr[8:0] in   instruction word, captured when a start is accepted
//   select     out  register index driven to the bus multiplexer
//   rSelect    out  put ALU result register G on the bus
//   immeSelect out  put the immediate operand on the bus
//   rIn[7:0]   out  one-hot load enable for R0..R7
//   aIn        out  load enable for ALU operand register A
//   gIn        out  load enable for ALU result register G
//   aluOp      out  00 add, 01 sub, 10 and
//   done       out  pulse in the final cycle of an instruction
//   busy       out  high in every state except T0
//
// Every output is decoded only from the state register and the captured
// instruction. run and instr therefore never reach an output directly.
// -----------------------------------------------------------------------------
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [8:0] instr,
  output logic [2:0] select,
  output logic       rSelect,
  output logic       immeSelect,
  output logic [7:0] rIn,
  output logic       aIn,
  output logic       gIn,
  output logic [1:0] aluOp,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  state_t     state_q;
  state_t     state_d;
  logic [8:0] ir_q;
  logic [8:0] ir_d;

  logic [2:0] opcode_s;
  logic [2:0] rx_s;
  logic [2:0] ry_s;
  logic [7:0] rx_onehot_s;

  assign opcode_s    = ir_q[8:6];
  assign rx_s        = ir_q[5:3];
  assign ry_s        = ir_q[2:0];
  assign rx_onehot_s = 8'd1 << rx_s;

  // Next-state and instruction-capture logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = instr;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        // Only the ALU operations need the extra operand and write-back cycles
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND: state_d = T2;
          default:                state_d = T0;
        endcase
      end
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // State and instruction registers; reset wins over a same-edge start
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode from state and captured instruction
  always_comb begin
    select     = 3'd0;
    rSelect    = 1'b0;
    immeSelect = 1'b0;
    rIn        = 8'd0;
    aIn        = 1'b0;
    gIn        = 1'b0;
    aluOp      = 2'b00;
    done       = 1'b0;
    busy       = 1'b0;
    case (state_q)
      T0: begin
        busy = 1'b0;
      end
      T1: begin
        busy = 1'b1;
        case (opcode_s)
          OP_MV: begin
            select = ry_s;
            rIn    = rx_onehot_s;
            done   = 1'b1;
          end
          OP_MVI: begin
            immeSelect = 1'b1;
            rIn        = rx_onehot_s;
            done       = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            select = rx_s;
            aIn    = 1'b1;
          end
          default: begin
            // nop: finishes immediately without touching the datapath
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        busy   = 1'b1;
        select = ry_s;
        gIn    = 1'b1;
        case (opcode_s)
          OP_ADD:  aluOp = 2'b00;
          OP_SUB:  aluOp = 2'b01;
          OP_AND:  aluOp = 2'b10;
          default: aluOp = 2'b00;
        endcase
      end
      T3: begin
        busy    = 1'b1;
        rSelect = 1'b1;
        rIn     = rx_onehot_s;
        done    = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] instr;
  logic [2:0] select;
  logic       rSelect;
  logic       immeSelect;
  logic [7:0] rIn;
  logic       aIn;
  logic       gIn;
  logic [1:0] aluOp;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Output vector: {select, rSelect, immeSelect, rIn, aIn, gIn, aluOp, done, busy}
  typedef logic [18:0] vec_t;
  localparam vec_t IDLE = 19'd0;

  // Expected output vectors still to come for the instruction in flight.
  // Each sequence ends with the T0 vector that follows done, so an empty
  // queue means the unit is sitting in T0 and will look at run.
  vec_t exp_q[$];

  unidade_controle dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .select     (select),
    .rSelect    (rSelect),
    .immeSelect (immeSelect),
    .rIn        (rIn),
    .aIn        (aIn),
    .gIn        (gIn),
    .aluOp      (aluOp),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic vec_t pack(input logic [2:0] sel, input logic rs, input logic is,
                                input logic [7:0] rin, input logic a, input logic g,
                                input logic [1:0] op, input logic d, input logic b);
    return {sel, rs, is, rin, a, g, op, d, b};
  endfunction

  // Reference behaviour: the per-cycle outputs an instruction produces
  function automatic void push_seq(input logic [8:0] ins);
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] oh;
    logic [1:0] alu;
    op  = ins[8:6];
    rx  = ins[5:3];
    ry  = ins[2:0];
    oh  = 8'd1 << rx;
    alu = 2'(op - 3'd2);  // add=0, sub=1, and=2
    if (op == 3'd0) begin
      exp_q.push_back(pack(ry, 1'b0, 1'b0, oh, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    end else if (op == 3'd1) begin
      exp_q.push_back(pack(3'd0, 1'b0, 1'b1, oh, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    end else if (op >= 3'd2 && op <= 3'd4) begin
      exp_q.push_back(pack(rx, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1));
      exp_q.push_back(pack(ry, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, alu, 1'b0, 1'b1));
      exp_q.push_back(pack(3'd0, 1'b1, 1'b0, oh, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(pack(3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    end
    exp_q.push_back(IDLE);
  endfunction

  // Advance one clock with current inputs, then check outputs against the model
  task automatic cyc(input string tag);
    vec_t e;
    vec_t act;
    logic ok;
    if (reset) begin
      exp_q.delete();
      e = IDLE;
    end else begin
      if (exp_q.size() == 0 && run) push_seq(instr);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = IDLE;
    end
    @(posedge clock);
    #1;
    act = {select, rSelect, immeSelect, rIn, aIn, gIn, aluOp, done, busy};
    checks++;
    assert (act === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, e);
    end
    ok = ($countones(rIn) <= 1) &&
         !(immeSelect && (rSelect || select != 3'd0)) &&
         !(rSelect && select != 3'd0);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s_excl: rIn=%b sel=%b rSel=%b imm=%b expected one-hot rIn and exclusive bus",
             tag, rIn, select, rSelect, immeSelect);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr = 9'd0;
    cyc("reset");
    reset = 1'b0;
    cyc("idle");

    // mv R2,R5
    run = 1'b1; instr = 9'b000_010_101;
    cyc("mv_t1");
    run = 1'b0;
    cyc("mv_t0");

    // mvi R7
    run = 1'b1; instr = 9'b001_111_000;
    cyc("mvi_t1");
    run = 1'b0;
    cyc("mvi_t0");

    // sub R1,R4
    run = 1'b1; instr = 9'b011_001_100;
    cyc("sub_t1");
    run = 1'b0;
    cyc("sub_t2");
    cyc("sub_t3");
    cyc("sub_t0");

    // Back-to-back: add R0,R1 then mv R3,R0 with run held, instr noise while busy
    run = 1'b1; instr = 9'b010_000_001;
    cyc("b2b_add_t1");
    instr = 9'h1FF;
    cyc("b2b_add_t2");
    instr = 9'b001_101_010;
    cyc("b2b_add_t3");
    instr = 9'b000_011_000;
    cyc("b2b_t0");
    cyc("b2b_mv_t1");
    run = 1'b0;
    cyc("b2b_mv_t0");

    // Reset during T2 of and R6,R2, with run high on the reset edge
    run = 1'b1; instr = 9'b100_110_010;
    cyc("and_t1");
    run = 1'b0;
    cyc("and_t2");
    reset = 1'b1; run = 1'b1;
    cyc("rst_mid");
    reset = 1'b0; run = 1'b0;
    cyc("rst_no_done");
    // Reset and run together in T0: start must be dropped
    reset = 1'b1; run = 1'b1; instr = 9'b000_001_010;
    cyc("rst_vs_run");
    reset = 1'b0; run = 1'b0;
    cyc("rst_vs_run_after");

    // nop (opcode 110)
    run = 1'b1; instr = 9'b110_100_011;
    cyc("nop_t1");
    run = 1'b0;
    cyc("nop_t0");

    // Add with Rx = Ry
    run = 1'b1; instr = 9'b010_011_011;
    cyc("addsame_t1");
    run = 1'b0;
    cyc("addsame_t2");
    cyc("addsame_t3");
    cyc("addsame_t0");

    // Random stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 24) == 0);
      run   = 1'($urandom_range(0, 1));
      instr = 9'($urandom);
      cyc("rand");
    end
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 4; i++) cyc("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
